// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped write-through cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

  localparam int NUM_LINES_DEF      = 32;
  localparam int WORDS_PER_LINE_DEF = 4;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int OFS_W  = 2;

  // Field widths for the default geometry.
  localparam int WSEL_W_DEF  = $clog2(WORDS_PER_LINE_DEF);
  localparam int INDEX_W_DEF = $clog2(NUM_LINES_DEF);
  localparam int TAG_W_DEF   = ADDR_W - INDEX_W_DEF - WSEL_W_DEF - OFS_W;
  localparam int LINE_W_DEF  = WORD_W * WORDS_PER_LINE_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

endpackage

// File: rtl/cache_if.sv
// Core-side load/store bus plus main-memory request bus of the cache.
// Latency: n/a (wiring only).
// Backpressure: core held by stall; memory side completes on mm_ready pulse.
interface cache_if;
  import cache_pkg::*;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     addr;
  logic [WORD_W-1:0]     wdata;
  logic [WORD_W-1:0]     rdata;
  logic                  stall;
  logic                  mm_rd_req;
  logic                  mm_wr_req;
  logic [ADDR_W-1:0]     mm_addr;
  logic [WORD_W-1:0]     mm_wdata;
  logic [LINE_W_DEF-1:0] mm_rdata;
  logic                  mm_ready;

  // Environment side: core requests in, memory responses in.
  modport master (
    output mem_read, mem_write, addr, wdata, mm_rdata, mm_ready,
    input  rdata, stall, mm_rd_req, mm_wr_req, mm_addr, mm_wdata
  );

  // Cache controller side.
  modport slave (
    input  mem_read, mem_write, addr, wdata, mm_rdata, mm_ready,
    output rdata, stall, mm_rd_req, mm_wr_req, mm_addr, mm_wdata
  );
endinterface

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays of the cache with one combinational read port.
// Latency: read is combinational; write lands on the next rising edge.
// Backpressure: none, a write is accepted every cycle wr_en is high.
module cache_line_store import cache_pkg::*; #(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int WORDS     = WORDS_PER_LINE_DEF,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = TAG_W_DEF,
  parameter int LINE_W    = WORD_W * WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic              wr_fill,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [WORDS-1:0]  wr_mask,
  input  logic [LINE_W-1:0] wr_line
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [LINE_W-1:0]    lines [NUM_LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_line  = lines[rd_idx];

  // Valid bits are the only reset state; a fill marks its line valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en && wr_fill) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data words; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_fill) begin
        tags[wr_idx] <= wr_tag;
      end
      for (int w = 0; w < WORDS; w++) begin
        if (wr_mask[w]) begin
          lines[wr_idx][w*WORD_W +: WORD_W] <= wr_line[w*WORD_W +: WORD_W];
        end
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through, no-write-allocate cache in front of main memory.
// Latency: read hit 0 cycles; read miss and writes wait for mm_ready.
// Backpressure: stall freezes the core while a memory transaction is pending.
module cache_controller import cache_pkg::*; #(
  parameter int NUM_LINES      = NUM_LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input logic clk,
  input logic rst_n,
  cache_if.slave bus
);

  localparam int SEL_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - SEL_W - OFS_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int LOW_W  = OFS_W + SEL_W;

  state_t state, next_state;

  logic [SEL_W-1:0]          wsel;
  logic [IDX_W-1:0]          idx;
  logic [TAG_W-1:0]          tag;
  logic                      line_valid;
  logic [TAG_W-1:0]          line_tag;
  logic [LINE_W-1:0]         line_data;
  logic                      hit;
  logic [WORD_W-1:0]         hit_word;
  logic                      wr_en;
  logic                      wr_fill;
  logic [WORDS_PER_LINE-1:0] wr_mask;
  logic [LINE_W-1:0]         wr_line;
  logic [OFS_W-1:0]          unused_byte_ofs;

  assign wsel            = bus.addr[OFS_W +: SEL_W];
  assign idx             = bus.addr[LOW_W +: IDX_W];
  assign tag             = bus.addr[ADDR_W-1 -: TAG_W];
  assign unused_byte_ofs = bus.addr[OFS_W-1:0];

  assign hit      = line_valid && (line_tag == tag);
  assign hit_word = line_data[wsel*WORD_W +: WORD_W];

  cache_line_store #(
    .NUM_LINES (NUM_LINES),
    .WORDS     (WORDS_PER_LINE),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_line  (line_data),
    .wr_en    (wr_en),
    .wr_fill  (wr_fill),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_mask  (wr_mask),
    .wr_line  (wr_line)
  );

  // State register; reset aborts any in-flight memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, core/memory outputs and line-store write controls.
  always_comb begin
    next_state    = state;
    bus.stall     = 1'b0;
    bus.rdata     = '0;
    bus.mm_rd_req = 1'b0;
    bus.mm_wr_req = 1'b0;
    bus.mm_addr   = '0;
    bus.mm_wdata  = '0;
    wr_en         = 1'b0;
    wr_fill       = 1'b0;
    wr_mask       = '0;
    wr_line       = bus.mm_rdata;

    unique case (state)
      IDLE: begin
        // A store wins over a simultaneous load; mm_ready is ignored here.
        if (bus.mem_write) begin
          bus.stall  = 1'b1;
          next_state = WR_THRU;
        end else if (bus.mem_read) begin
          if (hit) begin
            bus.rdata = hit_word;
          end else begin
            bus.stall  = 1'b1;
            next_state = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        // Stall stays high in the fill cycle; the load retries as a hit next cycle.
        bus.mm_rd_req = 1'b1;
        bus.mm_addr   = {bus.addr[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
        bus.stall     = 1'b1;
        if (bus.mm_ready) begin
          wr_en      = 1'b1;
          wr_fill    = 1'b1;
          wr_mask    = '1;
          next_state = IDLE;
        end
      end
      WR_THRU: begin
        // Write-through; only a resident line gets its word patched.
        bus.mm_wr_req = 1'b1;
        bus.mm_addr   = bus.addr;
        bus.mm_wdata  = bus.wdata;
        bus.stall     = 1'b1;
        wr_line       = {WORDS_PER_LINE{bus.wdata}};
        if (bus.mm_ready) begin
          bus.stall  = 1'b0;
          next_state = IDLE;
          if (hit) begin
            wr_en         = 1'b1;
            wr_mask[wsel] = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: expected load data is queued when a
// load is issued and compared when the core is released (stall=0).
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cache_if cif();

  cache_controller #(
    .NUM_LINES      (32),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mem_m [logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Main-memory contents: explicit writes, otherwise an address-derived pattern.
  function automatic logic [31:0] mword(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] mline(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0000};
    return {mword(b + 32'd12), mword(b + 32'd8), mword(b + 32'd4), mword(b)};
  endfunction

  // Wait (bounded) for the core to be released, then score the load data.
  task automatic finish_read();
    logic [31:0] e;
    for (int n = 0; n < 16 && cif.stall; n++) begin
      @(negedge clk); #1;
    end
    if (cif.stall) begin
      check_eq("rd_release_timeout", 32'(cif.stall), 32'd0);
    end else if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("rdata", cif.rdata, e);
    end
    @(negedge clk);
    cif.mem_read = 1'b0;
    #1;
    check_eq("idle_rdata_zero", cif.rdata, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input bit exp_hit, input int lat);
    int n;
    @(negedge clk);
    cif.mem_read = 1'b1;
    cif.addr     = a;
    exp_q.push_back(mword(a));
    #1;
    check_eq(exp_hit ? "hit_no_stall" : "miss_stall", 32'(cif.stall), exp_hit ? 32'd0 : 32'd1);
    if (exp_hit) begin
      check_eq("hit_no_rdreq", 32'(cif.mm_rd_req), 32'd0);
    end else begin
      n = 0;
      do begin
        @(negedge clk); #1;
        n++;
      end while (!cif.mm_rd_req && n < 8);
      check_eq("rd_req", 32'(cif.mm_rd_req), 32'd1);
      check_eq("rd_addr", cif.mm_addr, {a[31:4], 4'b0000});
      check_eq("rd_no_wrreq", 32'(cif.mm_wr_req), 32'd0);
      repeat (lat - 1) begin
        @(negedge clk); #1;
      end
      check_eq("rd_wait_stall", 32'(cif.stall), 32'd1);
      @(negedge clk);
      cif.mm_ready = 1'b1;
      cif.mm_rdata = mline(a);
      #1;
      check_eq("fill_cycle_stall", 32'(cif.stall), 32'd1);
      @(negedge clk);
      cif.mm_ready = 1'b0;
      #1;
    end
    finish_read();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit also_read);
    @(negedge clk);
    cif.mem_write = 1'b1;
    cif.mem_read  = also_read;
    cif.addr      = a;
    cif.wdata     = d;
    #1;
    check_eq("wr_stall", 32'(cif.stall), 32'd1);
    check_eq("wr_idle_no_req", 32'(cif.mm_wr_req), 32'd0);
    @(negedge clk); #1;
    check_eq("wr_req", 32'(cif.mm_wr_req), 32'd1);
    check_eq("wr_addr", cif.mm_addr, a);
    check_eq("wr_data", cif.mm_wdata, d);
    check_eq("wr_no_rdreq", 32'(cif.mm_rd_req), 32'd0);
    @(negedge clk); #1;
    check_eq("wr_wait_stall", 32'(cif.stall), 32'd1);
    @(negedge clk);
    cif.mm_ready = 1'b1;
    #1;
    check_eq("wr_done_stall", 32'(cif.stall), 32'd0);
    mem_m[a] = d;
    @(negedge clk);
    cif.mm_ready  = 1'b0;
    cif.mem_write = 1'b0;
    cif.mem_read  = 1'b0;
    #1;
    check_eq("wr_after_no_wrreq", 32'(cif.mm_wr_req), 32'd0);
    check_eq("wr_after_no_rdreq", 32'(cif.mm_rd_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    cif.mem_read  = 1'b0;
    cif.mem_write = 1'b0;
    cif.addr      = '0;
    cif.wdata     = '0;
    cif.mm_rdata  = '0;
    cif.mm_ready  = 1'b0;
    mem_m[32'h40] = 32'd1;
    mem_m[32'h44] = 32'd2;
    mem_m[32'h48] = 32'd3;
    mem_m[32'h4C] = 32'd4;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(cif.stall), 32'd0);
    check_eq("rst_rdata", cif.rdata, 32'd0);
    check_eq("rst_rdreq", 32'(cif.mm_rd_req), 32'd0);
    check_eq("rst_wrreq", 32'(cif.mm_wr_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss and refill, then a hit in the same line.
    do_read(32'h0000_0040, 1'b0, 3);
    do_read(32'h0000_0048, 1'b1, 0);

    // Write hit updates memory and the resident word.
    do_write(32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h0000_0044, 1'b1, 0);

    // Conflict on index 4: evict and come back.
    do_read(32'h0000_0240, 1'b0, 2);
    do_read(32'h0000_0040, 1'b0, 1);
    do_read(32'h0000_0044, 1'b1, 0);

    // Write miss does not allocate.
    do_write(32'h0000_1000, 32'h1234_5678, 1'b0);
    do_read(32'h0000_1000, 1'b0, 2);

    // Simultaneous load and store: store wins, no read traffic.
    do_write(32'h0000_0048, 32'hCAFE_F00D, 1'b1);
    do_read(32'h0000_0048, 1'b1, 0);

    // Stray mm_ready in IDLE is ignored.
    @(negedge clk);
    cif.mm_ready = 1'b1;
    #1;
    check_eq("idle_ready_stall", 32'(cif.stall), 32'd0);
    check_eq("idle_ready_rdata", cif.rdata, 32'd0);
    @(negedge clk);
    cif.mm_ready = 1'b0;
    #1;
    check_eq("idle_ready_no_rdreq", 32'(cif.mm_rd_req), 32'd0);
    check_eq("idle_ready_no_wrreq", 32'(cif.mm_wr_req), 32'd0);

    // Reset in the middle of a refill aborts it immediately.
    @(negedge clk);
    cif.mem_read = 1'b1;
    cif.addr     = 32'h0000_0300;
    #1;
    check_eq("abort_miss_stall", 32'(cif.stall), 32'd1);
    @(negedge clk); #1;
    check_eq("abort_rdreq_before", 32'(cif.mm_rd_req), 32'd1);
    #2;
    rst_n        = 1'b0;
    cif.mem_read = 1'b0;
    #1;
    check_eq("abort_stall", 32'(cif.stall), 32'd0);
    check_eq("abort_rdreq", 32'(cif.mm_rd_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cif.mm_ready = 1'b1;
    cif.mm_rdata = mline(32'h0000_0300);
    #1;
    check_eq("late_ready_no_rdreq", 32'(cif.mm_rd_req), 32'd0);
    @(negedge clk);
    cif.mm_ready = 1'b0;
    do_read(32'h0000_0300, 1'b0, 2);
    do_read(32'h0000_0040, 1'b0, 1);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
